// File: rtl/fetch_seq_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_seq_pkg;

  typedef enum logic [2:0] {
    ST_BOOT  = 3'd0,
    ST_FETCH = 3'd1,
    ST_HOLD  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_FAULT = 3'd4
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PC_INCR   = 32'd4;

endpackage

// File: rtl/fetch_slot.sv
// One-entry valid/ready output register; flush drops the entry but keeps the data.
module fetch_slot
  import fetch_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] load_instr,
  input  logic [31:0] load_pc,
  input  logic        flush,
  input  logic        ready,
  output logic        valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
);

  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;

  always_comb begin
    valid_d    = valid_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d    = 1'b1;
      instr_d    = load_instr;
      instr_pc_d = load_pc;
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= 1'b0;
      instr_q    <= NOP_INSTR;
      instr_pc_q <= 32'h0;
    end else begin
      valid_q    <= valid_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
    end
  end

  assign valid    = valid_q;
  assign instr    = instr_q;
  assign instr_pc = instr_pc_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer with redirect handling; FETCH_SEQ_MISALIGN_TRAP_EN enables the misaligned-redirect trap.
//   state | meaning
//   BOOT  | one idle cycle after reset, no request
//   FETCH | request outstanding at req_addr_q
//   HOLD  | slot full, waiting for decode to take it
//   DRAIN | redirect pending, old request must still complete
//   FAULT | misaligned redirect trapped, only reset exits
module fetch_sequencer
  import fetch_seq_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
)
(
  input  logic        CLK,
  input  logic        Reset,
  input  logic        PCSrc,
  input  logic [31:0] Result,
  output logic        IMem_Req,
  output logic [31:0] IMem_Addr,
  input  logic        IMem_Ack,
  input  logic [31:0] IMem_RData,
  output logic        Instr_Valid,
  input  logic        Instr_Ready,
  output logic [31:0] Instr,
  output logic [31:0] Instr_PC,
  output logic [31:0] PC,
  output logic        Misalign_Fault
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  req_addr_q, req_addr_d;
  logic         req_q, req_d;
  logic         fault_q, fault_d;
  logic         slot_load, slot_flush, slot_valid;
  logic         slot_free, slot_xfer;
  logic [31:0]  target, pc_next_seq;
  logic         misalign;

`ifdef FETCH_SEQ_MISALIGN_TRAP_EN
  assign target   = Result;
  assign misalign = |Result[1:0];
`else
  logic unused_result_lsb;
  assign unused_result_lsb = ^Result[1:0];
  assign target   = {Result[31:2], 2'b00};
  assign misalign = 1'b0;
`endif

  assign pc_next_seq = pc_q + PC_INCR;
  assign slot_free   = ~slot_valid | Instr_Ready;
  assign slot_xfer   = slot_valid & Instr_Ready;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    req_d      = req_q;
    fault_d    = fault_q;
    slot_load  = 1'b0;
    slot_flush = 1'b0;
    case (state_q)
      ST_BOOT: begin
        state_d = ST_FETCH;
        req_d   = 1'b1;
        if (PCSrc) begin
          slot_flush = 1'b1;
          pc_d       = target;
          req_addr_d = target;
        end
      end
      ST_FETCH: begin
        if (PCSrc) begin
          slot_flush = 1'b1;
          pc_d       = target;
          if (IMem_Ack) req_addr_d = target;
          else          state_d    = ST_DRAIN;
        end else if (IMem_Ack) begin
          // An Ack that cannot enter the slot is dropped and the word refetched from HOLD.
          if (slot_free) begin
            slot_load  = 1'b1;
            pc_d       = pc_next_seq;
            req_addr_d = pc_next_seq;
          end else begin
            state_d = ST_HOLD;
            req_d   = 1'b0;
          end
        end
      end
      ST_HOLD: begin
        if (PCSrc) begin
          slot_flush = 1'b1;
          pc_d       = target;
          req_addr_d = target;
          state_d    = ST_FETCH;
          req_d      = 1'b1;
        end else if (slot_xfer) begin
          state_d = ST_FETCH;
          req_d   = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (PCSrc) begin
          slot_flush = 1'b1;
          pc_d       = target;
        end
        if (IMem_Ack) begin
          state_d    = ST_FETCH;
          req_addr_d = pc_d;
        end
      end
      ST_FAULT: begin
        if (IMem_Ack) req_d = 1'b0;
      end
      default: begin
        state_d = ST_BOOT;
        req_d   = 1'b0;
      end
    endcase
    // The trap overrides every state; an in-flight request keeps Req high until its Ack.
    if (PCSrc && misalign && (state_q != ST_FAULT)) begin
      state_d    = ST_FAULT;
      fault_d    = 1'b1;
      slot_load  = 1'b0;
      slot_flush = 1'b1;
      pc_d       = pc_q;
      req_addr_d = req_addr_q;
      req_d      = req_q & ~IMem_Ack;
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_VECTOR;
      req_addr_q <= RESET_VECTOR;
      req_q      <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      req_q      <= req_d;
      fault_q    <= fault_d;
    end
  end

  fetch_slot u_slot (
    .clk        (CLK),
    .rst        (Reset),
    .load       (slot_load),
    .load_instr (IMem_RData),
    .load_pc    (req_addr_q),
    .flush      (slot_flush),
    .ready      (Instr_Ready),
    .valid      (slot_valid),
    .instr      (Instr),
    .instr_pc   (Instr_PC)
  );

  assign Instr_Valid    = slot_valid;
  assign IMem_Req       = req_q;
  assign IMem_Addr      = req_addr_q;
  assign PC             = pc_q;
  assign Misalign_Fault = fault_q;

endmodule
